// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared arbiter state encoding, AXI-lite response codes and bus widths
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_RD = 2'd1,
    GRANT_WR = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI-lite bundle with master and slave views
interface axi_lite_if
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// rtl/axi_lite_arbiter_rr_arb2.sv - combinational 2-way picker, contention goes to the side not granted last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two AXI-lite masters sharing one slave, one whole transaction per grant
module axi_lite_arbiter
  import axi_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  arb_state_e r_state;
  logic       r_owner;
  logic       r_last;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_last;
  logic       w_win_ar;
  logic       w_rd, w_wr;
  logic       w_rd0, w_rd1, w_wr0, w_wr1;

  assign w_req    = {m1.arvalid | m1.awvalid | m1.wvalid, m0.arvalid | m0.awvalid | m0.wvalid};
  // Fixed priority reuses the picker: "m0 was last" always favours m1.
  assign w_last   = RR_EN ? r_last : 1'b0;
  assign w_win_ar = w_gnt[1] ? m1.arvalid : m0.arvalid;

  rr_arb2 u_pick (
    .req  (w_req),
    .last (w_last),
    .gnt  (w_gnt)
  );

  logic w_own_rready, w_own_bready;
  assign w_own_rready = r_owner ? m1.rready : m0.rready;
  assign w_own_bready = r_owner ? m1.bready : m0.bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner <= w_gnt[1];
            r_last  <= w_gnt[1];
            r_state <= w_win_ar ? GRANT_RD : GRANT_WR;
          end
        end
        GRANT_RD: if (s.rvalid && w_own_rready) r_state <= IDLE;
        GRANT_WR: if (s.bvalid && w_own_bready) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign w_rd  = (r_state == GRANT_RD);
  assign w_wr  = (r_state == GRANT_WR);
  assign w_rd0 = w_rd & ~r_owner;
  assign w_rd1 = w_rd &  r_owner;
  assign w_wr0 = w_wr & ~r_owner;
  assign w_wr1 = w_wr &  r_owner;

  assign s.araddr  = w_rd ? (r_owner ? m1.araddr : m0.araddr) : '0;
  assign s.arvalid = w_rd & (r_owner ? m1.arvalid : m0.arvalid);
  assign s.rready  = w_rd & w_own_rready;
  assign s.awaddr  = w_wr ? (r_owner ? m1.awaddr : m0.awaddr) : '0;
  assign s.awvalid = w_wr & (r_owner ? m1.awvalid : m0.awvalid);
  assign s.wdata   = w_wr ? (r_owner ? m1.wdata : m0.wdata) : '0;
  assign s.wstrb   = w_wr ? (r_owner ? m1.wstrb : m0.wstrb) : '0;
  assign s.wvalid  = w_wr & (r_owner ? m1.wvalid : m0.wvalid);
  assign s.bready  = w_wr & w_own_bready;

  assign m0.arready = w_rd0 & s.arready;
  assign m0.rvalid  = w_rd0 & s.rvalid;
  assign m0.rdata   = w_rd0 ? s.rdata : '0;
  assign m0.rresp   = w_rd0 ? s.rresp : '0;
  assign m0.awready = w_wr0 & s.awready;
  assign m0.wready  = w_wr0 & s.wready;
  assign m0.bvalid  = w_wr0 & s.bvalid;
  assign m0.bresp   = w_wr0 ? s.bresp : '0;

  assign m1.arready = w_rd1 & s.arready;
  assign m1.rvalid  = w_rd1 & s.rvalid;
  assign m1.rdata   = w_rd1 ? s.rdata : '0;
  assign m1.rresp   = w_rd1 ? s.rresp : '0;
  assign m1.awready = w_wr1 & s.awready;
  assign m1.wready  = w_wr1 & s.wready;
  assign m1.bvalid  = w_wr1 & s.bvalid;
  assign m1.bresp   = w_wr1 ? s.bresp : '0;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed checks of axi_lite_arbiter, round-robin and fixed-priority instances
module tb_axi_lite_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_lite_if ma0 (), ma1 (), sa ();
  axi_lite_if mb0 (), mb1 (), sb ();

  axi_lite_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .m0(ma0), .m1(ma1), .s(sa));
  axi_lite_arbiter #(.RR_EN(1'b0)) dut_fx (.clk(clk), .rst(rst), .m0(mb0), .m1(mb1), .s(sb));

  // The fixed-priority instance sees exactly the same stimulus.
  assign mb0.araddr = ma0.araddr;  assign mb0.arvalid = ma0.arvalid; assign mb0.rready = ma0.rready;
  assign mb0.awaddr = ma0.awaddr;  assign mb0.awvalid = ma0.awvalid; assign mb0.wdata  = ma0.wdata;
  assign mb0.wstrb  = ma0.wstrb;   assign mb0.wvalid  = ma0.wvalid;  assign mb0.bready = ma0.bready;
  assign mb1.araddr = ma1.araddr;  assign mb1.arvalid = ma1.arvalid; assign mb1.rready = ma1.rready;
  assign mb1.awaddr = ma1.awaddr;  assign mb1.awvalid = ma1.awvalid; assign mb1.wdata  = ma1.wdata;
  assign mb1.wstrb  = ma1.wstrb;   assign mb1.wvalid  = ma1.wvalid;  assign mb1.bready = ma1.bready;
  assign sb.arready = sa.arready;  assign sb.rdata  = sa.rdata;      assign sb.rresp   = sa.rresp;
  assign sb.rvalid  = sa.rvalid;   assign sb.awready = sa.awready;   assign sb.wready  = sa.wready;
  assign sb.bresp   = sa.bresp;    assign sb.bvalid = sa.bvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    ma0.araddr = '0; ma0.arvalid = 0; ma0.rready = 0; ma0.awaddr = '0; ma0.awvalid = 0;
    ma0.wdata = '0;  ma0.wstrb = '0;  ma0.wvalid = 0; ma0.bready = 0;
    ma1.araddr = '0; ma1.arvalid = 0; ma1.rready = 0; ma1.awaddr = '0; ma1.awvalid = 0;
    ma1.wdata = '0;  ma1.wstrb = '0;  ma1.wvalid = 0; ma1.bready = 0;
    sa.arready = 0; sa.rdata = '0; sa.rresp = '0; sa.rvalid = 0;
    sa.awready = 0; sa.wready = 0; sa.bresp = '0; sa.bvalid = 0;
  endtask

  initial begin
    // Reset: everything quiet even with activity on every input.
    idle_all();
    ma0.arvalid = 1; ma0.araddr = 32'h8000_0000; ma1.wvalid = 1; ma1.wdata = 32'h1111_2222;
    sa.arready = 1; sa.rvalid = 1; sa.rdata = 32'hDEAD_BEEF; sa.rresp = RESP_SLVERR; sa.bvalid = 1;
    #1;
    chk1("rst_s_arvalid", sa.arvalid, 1'b0);
    chk ("rst_s_araddr", sa.araddr, 32'h0);
    chk1("rst_s_wvalid", sa.wvalid, 1'b0);
    chk ("rst_s_wdata", sa.wdata, 32'h0);
    chk1("rst_m0_arready", ma0.arready, 1'b0);
    chk1("rst_m0_rvalid", ma0.rvalid, 1'b0);
    chk ("rst_m0_rdata", ma0.rdata, 32'h0);
    chk ("rst_m0_rresp", 32'(ma0.rresp), 32'h0);
    chk1("rst_m1_bvalid", ma1.bvalid, 1'b0);
    tick(); tick();
    idle_all();
    rst = 0;

    // Lone m0 read: one cycle of arbitration, then zero-latency routing.
    tick();
    ma0.araddr = 32'h8000_0000; ma0.arvalid = 1; ma0.rready = 1; sa.arready = 1;
    #1 chk1("rd_arb_latency", sa.arvalid, 1'b0);
    tick();
    #1;
    chk1("rd_s_arvalid", sa.arvalid, 1'b1);
    chk ("rd_s_araddr", sa.araddr, 32'h8000_0000);
    chk1("rd_m0_arready", ma0.arready, 1'b1);
    tick();
    ma0.arvalid = 0; sa.rvalid = 1; sa.rdata = 32'hDEAD_BEEF; sa.rresp = RESP_OKAY;
    #1;
    chk1("rd_m0_rvalid", ma0.rvalid, 1'b1);
    chk ("rd_m0_rdata", ma0.rdata, 32'hDEAD_BEEF);
    chk1("rd_m1_rvalid", ma1.rvalid, 1'b0);
    chk1("rd_s_rready", sa.rready, 1'b1);
    tick();
    sa.rvalid = 0;
    #1 chk1("rd_release_rready", sa.rready, 1'b0);

    // m1 write with W two cycles ahead of AW while m0 waits to read.
    sa.awready = 1; sa.wready = 1;
    ma1.wvalid = 1; ma1.wdata = 32'h1234_5678; ma1.wstrb = 4'hF; ma1.bready = 1;
    #1 chk1("wr_arb_latency", sa.wvalid, 1'b0);
    tick();
    ma0.arvalid = 1; ma0.araddr = 32'h0000_0040;
    #1;
    chk1("wr_s_wvalid", sa.wvalid, 1'b1);
    chk ("wr_s_wdata", sa.wdata, 32'h1234_5678);
    chk ("wr_s_wstrb", 32'(sa.wstrb), 32'hF);
    chk1("wr_m1_wready", ma1.wready, 1'b1);
    chk1("wr_block_rd", sa.arvalid, 1'b0);
    chk1("wr_m0_arready", ma0.arready, 1'b0);
    tick();
    ma1.wvalid = 0; ma1.awvalid = 1; ma1.awaddr = 32'h0000_1000;
    #1;
    chk1("wr_s_awvalid", sa.awvalid, 1'b1);
    chk ("wr_s_awaddr", sa.awaddr, 32'h0000_1000);
    chk1("wr_m1_awready", ma1.awready, 1'b1);
    tick();
    ma1.awvalid = 0; sa.bvalid = 1; sa.bresp = RESP_OKAY;
    #1;
    chk1("wr_m1_bvalid", ma1.bvalid, 1'b1);
    chk ("wr_m1_bresp", 32'(ma1.bresp), 32'(RESP_OKAY));
    chk1("wr_m0_bvalid", ma0.bvalid, 1'b0);
    chk1("wr_s_bready", sa.bready, 1'b1);
    tick();
    sa.bvalid = 0;
    #1 chk1("wr_then_rd_gap", sa.arvalid, 1'b0);
    tick();
    #1;
    chk1("wr_then_rd_arvalid", sa.arvalid, 1'b1);
    chk ("wr_then_rd_araddr", sa.araddr, 32'h0000_0040);
    tick();
    ma0.arvalid = 0; sa.rvalid = 1; sa.rdata = 32'h0000_0A40;
    #1 chk("wr_then_rd_rdata", ma0.rdata, 32'h0000_0A40);
    tick();
    sa.rvalid = 0;

    // SLVERR read for m1: passed through, grant released normally.
    ma1.arvalid = 1; ma1.araddr = 32'h0000_2000; ma1.rready = 1;
    tick();
    #1 chk1("err_m1_arready", ma1.arready, 1'b1);
    tick();
    ma1.arvalid = 0; sa.rvalid = 1; sa.rdata = 32'hCAFE_0001; sa.rresp = RESP_SLVERR;
    #1;
    chk1("err_m1_rvalid", ma1.rvalid, 1'b1);
    chk ("err_m1_rresp", 32'(ma1.rresp), 32'(RESP_SLVERR));
    chk ("err_m1_rdata", ma1.rdata, 32'hCAFE_0001);
    chk1("err_m0_rvalid", ma0.rvalid, 1'b0);
    chk ("err_m0_rresp", 32'(ma0.rresp), 32'h0);
    chk ("err_m0_rdata", ma0.rdata, 32'h0);
    tick();
    sa.rvalid = 0; sa.rresp = RESP_OKAY;
    #1 chk1("err_release_rready", sa.rready, 1'b0);

    // m0 stalls R for 10 cycles while m1 keeps requesting.
    ma0.arvalid = 1; ma0.araddr = 32'h0000_0500; ma0.rready = 0;
    tick();
    #1 chk1("stall_grant", sa.arvalid, 1'b1);
    tick();
    ma0.arvalid = 0; sa.rvalid = 1; sa.rdata = 32'h0000_0055;
    ma1.arvalid = 1; ma1.araddr = 32'h0000_3000; ma1.rready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("stall_s_rready", sa.rready, 1'b0);
      chk1("stall_m0_rvalid", ma0.rvalid, 1'b1);
      chk1("stall_m1_arready", ma1.arready, 1'b0);
      chk ("stall_s_araddr", sa.araddr, 32'h0000_0500);
      tick();
    end
    ma0.rready = 1;
    #1 chk1("stall_done_rready", sa.rready, 1'b1);
    tick();
    sa.rvalid = 0;
    #1 chk1("stall_next_gap", sa.arvalid, 1'b0);
    tick();
    #1;
    chk ("stall_next_araddr", sa.araddr, 32'h0000_3000);
    chk1("stall_next_arready", ma1.arready, 1'b1);
    tick();
    ma1.arvalid = 0; sa.rvalid = 1;
    tick();
    sa.rvalid = 0;

    // Reset mid-write: AW done, W stalled by the slave.
    ma1.awvalid = 1; ma1.awaddr = 32'h0000_1000; ma1.bready = 1; sa.wready = 0;
    tick();
    #1 chk1("rstw_awvalid", sa.awvalid, 1'b1);
    tick();
    ma1.awvalid = 0; ma1.wvalid = 1; ma1.wdata = 32'hAAAA_5555; ma1.wstrb = 4'h3;
    #1;
    chk1("rstw_wvalid_pre", sa.wvalid, 1'b1);
    chk ("rstw_wdata_pre", sa.wdata, 32'hAAAA_5555);
    rst = 1;
    #1;
    chk1("rstw_wvalid", sa.wvalid, 1'b0);
    chk ("rstw_wdata", sa.wdata, 32'h0);
    chk ("rstw_wstrb", 32'(sa.wstrb), 32'h0);
    chk1("rstw_bready", sa.bready, 1'b0);
    chk1("rstw_m1_wready", ma1.wready, 1'b0);
    tick(); tick();
    rst = 0;
    #1 chk1("rstw_idle_after", sa.wvalid, 1'b0);
    idle_all();

    // Constant read contention: RR alternates from m0, fixed priority always m1.
    ma0.arvalid = 1; ma0.araddr = 32'h0000_00A0; ma0.rready = 1;
    ma1.arvalid = 1; ma1.araddr = 32'h0000_00B0; ma1.rready = 1;
    sa.arready = 1;
    for (int r = 0; r < 4; r++) begin
      tick();
      #1;
      chk ("rr_grant_addr", sa.araddr, (r % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
      chk1("rr_m0_arready", ma0.arready, (r % 2 == 0));
      chk ("fx_grant_addr", sb.araddr, 32'h0000_00B0);
      tick();
      sa.rvalid = 1; sa.rdata = 32'(r);
      #1;
      chk1("rr_m1_rvalid", ma1.rvalid, (r % 2 == 1));
      chk1("fx_m1_rvalid", mb1.rvalid, 1'b1);
      tick();
      sa.rvalid = 0;
    end
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
